mont_exp_ctrl: RTL and testbench

Sequencer that computes modular exponentiation result = x^e mod m by driving one shared `montgomery` multiplier instance through its start/done handshake. It uses left-to-right square-and-multiply in the Montgomery domain. It sits between the top-level RSA/command interface and the `montgomery` datapath. It owns all operand muxing into the multiplier and the accumulator register.

---
 rtl/mont_pkg.sv | 26 ++
 rtl/mont_exp_ctrl_if.sv | 22 ++
 rtl/mont_opmux.sv | 42 ++++
 rtl/mont_exp_ctrl.sv | 158 +++++++++++++++
 tb/tb_mont_exp_ctrl.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mont_pkg.sv
// Shared encodings and widths for the Montgomery exponentiation sequencer.
package mont_pkg;

  localparam int DW  = 512;
  localparam int OPW = 514;

  typedef enum logic [1:0] {
    OP_PRE  = 2'd0,
    OP_SQR  = 2'd1,
    OP_MUL  = 2'd2,
    OP_POST = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LAUNCH = 3'd1,
    ST_WAIT   = 3'd2,
    ST_NEXT   = 3'd3,
    ST_FINISH = 3'd4
  } state_e;

  function automatic logic [OPW-1:0] zext(input logic [DW-1:0] v);
    return {{(OPW-DW){1'b0}}, v};
  endfunction

endpackage

// File: rtl/mont_exp_ctrl_if.sv
// Start/done handshake and operand bus between the sequencer and the multiplier.
interface mont_exp_ctrl_if;
  import mont_pkg::*;

  logic           mm_start;
  logic [OPW-1:0] mm_a;
  logic [OPW-1:0] mm_b;
  logic [OPW-1:0] mm_m;
  logic [DW-1:0]  mm_result;
  logic           mm_done;

  modport master (
    output mm_start, mm_a, mm_b, mm_m,
    input  mm_result, mm_done
  );

  modport slave (
    input  mm_start, mm_a, mm_b, mm_m,
    output mm_result, mm_done
  );

endinterface

// File: rtl/mont_opmux.sv
// Operand selection into the multiplier for each exponentiation step.
module mont_opmux
  import mont_pkg::*;
(
  input  op_e            op,
  input  logic [DW-1:0]  acc,
  input  logic [DW-1:0]  xt,
  input  logic [DW-1:0]  x,
  input  logic [DW-1:0]  r2,
  output logic [OPW-1:0] a,
  output logic [OPW-1:0] b
);

  always_comb begin
    a = '0;
    b = '0;
    case (op)
      OP_PRE: begin
        a = zext(x);
        b = zext(r2);
      end
      OP_SQR: begin
        a = zext(acc);
        b = zext(acc);
      end
      OP_MUL: begin
        a = zext(acc);
        b = zext(xt);
      end
      OP_POST: begin
        // Multiplying by plain 1 strips the Montgomery factor R.
        a = zext(acc);
        b = OPW'(1);
      end
      default: begin
        a = '0;
        b = '0;
      end
    endcase
  end

endmodule

// File: rtl/mont_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer computing x^e mod m through one
// shared Montgomery multiplier.
module mont_exp_ctrl
  import mont_pkg::*;
#(
  parameter int E_WIDTH = 512,
  parameter int ELEN_W  = 10
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic [DW-1:0]         in_x,
  input  logic [E_WIDTH-1:0]    in_e,
  input  logic [ELEN_W-1:0]     in_elen,
  input  logic [DW-1:0]         in_m,
  input  logic [DW-1:0]         in_r,
  input  logic [DW-1:0]         in_r2,
  mont_exp_ctrl_if.master       mm,
  output logic                  busy,
  output logic                  done,
  output logic [DW-1:0]         result
);

  localparam int IDX_W = (E_WIDTH > 1) ? $clog2(E_WIDTH) : 1;

  state_e               state_reg, state_next;
  op_e                  op_reg, op_next;
  logic [IDX_W-1:0]     idx_reg, idx_next;
  logic                 elen_nz_reg, elen_nz_next;
  logic [E_WIDTH-1:0]   e_reg, e_next;
  logic [DW-1:0]        x_reg, x_next;
  logic [DW-1:0]        m_reg, m_next;
  logic [DW-1:0]        r2_reg, r2_next;
  logic [DW-1:0]        acc_reg, acc_next;
  logic [DW-1:0]        xt_reg, xt_next;
  logic [DW-1:0]        result_reg, result_next;

  logic [ELEN_W-1:0]    elen_clamped;
  logic                 bit_last;

  assign elen_clamped = (in_elen > ELEN_W'(E_WIDTH)) ? ELEN_W'(E_WIDTH) : in_elen;
  assign bit_last     = (idx_reg == '0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg   <= ST_IDLE;
      op_reg      <= OP_PRE;
      idx_reg     <= '0;
      elen_nz_reg <= 1'b0;
      e_reg       <= '0;
      x_reg       <= '0;
      m_reg       <= '0;
      r2_reg      <= '0;
      acc_reg     <= '0;
      xt_reg      <= '0;
      result_reg  <= '0;
    end else begin
      state_reg   <= state_next;
      op_reg      <= op_next;
      idx_reg     <= idx_next;
      elen_nz_reg <= elen_nz_next;
      e_reg       <= e_next;
      x_reg       <= x_next;
      m_reg       <= m_next;
      r2_reg      <= r2_next;
      acc_reg     <= acc_next;
      xt_reg      <= xt_next;
      result_reg  <= result_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    op_next      = op_reg;
    idx_next     = idx_reg;
    elen_nz_next = elen_nz_reg;
    e_next       = e_reg;
    x_next       = x_reg;
    m_next       = m_reg;
    r2_next      = r2_reg;
    acc_next     = acc_reg;
    xt_next      = xt_reg;
    result_next  = result_reg;

    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          x_next       = in_x;
          e_next       = in_e;
          m_next       = in_m;
          r2_next      = in_r2;
          acc_next     = in_r;
          elen_nz_next = (elen_clamped != '0);
          idx_next     = IDX_W'(elen_clamped - ELEN_W'(1));
          op_next      = OP_PRE;
          state_next   = ST_LAUNCH;
        end
      end
      ST_LAUNCH: state_next = ST_WAIT;
      ST_WAIT: begin
        if (mm.mm_done) begin
          if (op_reg == OP_PRE) xt_next = mm.mm_result;
          else                  acc_next = mm.mm_result;
          state_next = ST_NEXT;
        end
      end
      ST_NEXT: begin
        state_next = ST_LAUNCH;
        case (op_reg)
          OP_PRE: op_next = elen_nz_reg ? OP_SQR : OP_POST;
          OP_SQR: begin
            if (e_reg[idx_reg]) begin
              op_next = OP_MUL;
            end else if (bit_last) begin
              op_next = OP_POST;
            end else begin
              idx_next = idx_reg - IDX_W'(1);
              op_next  = OP_SQR;
            end
          end
          OP_MUL: begin
            if (bit_last) begin
              op_next = OP_POST;
            end else begin
              idx_next = idx_reg - IDX_W'(1);
              op_next  = OP_SQR;
            end
          end
          default: begin
            // Result is loaded on entry to FINISH so it is valid alongside done.
            result_next = acc_reg;
            state_next  = ST_FINISH;
          end
        endcase
      end
      ST_FINISH: state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  mont_opmux u_opmux (
    .op  (op_reg),
    .acc (acc_reg),
    .xt  (xt_reg),
    .x   (x_reg),
    .r2  (r2_reg),
    .a   (mm.mm_a),
    .b   (mm.mm_b)
  );

  assign mm.mm_start = (state_reg == ST_LAUNCH);
  assign mm.mm_m     = zext(m_reg);
  assign busy        = (state_reg == ST_LAUNCH) || (state_reg == ST_WAIT) ||
                       (state_reg == ST_NEXT);
  assign done        = (state_reg == ST_FINISH);
  assign result      = result_reg;

endmodule

// File: tb/tb_mont_exp_ctrl.sv
// Directed bench for mont_exp_ctrl with a behavioural Montgomery responder and
// an expected-result scoreboard.
module tb_mont_exp_ctrl;
  import mont_pkg::*;

  localparam int EW = 512;
  localparam int LW = 10;

  logic            clk = 1'b0;
  logic            resetn = 1'b0;
  logic            start = 1'b0;
  logic [DW-1:0]   in_x = '0;
  logic [EW-1:0]   in_e = '0;
  logic [LW-1:0]   in_elen = '0;
  logic [DW-1:0]   in_m = '0;
  logic [DW-1:0]   in_r = '0;
  logic [DW-1:0]   in_r2 = '0;
  logic            busy;
  logic            done;
  logic [DW-1:0]   result;

  mont_exp_ctrl_if mif();

  logic            mm_done_rsp = 1'b0;
  logic            spur_done = 1'b0;
  logic [DW-1:0]   mm_res = '0;

  assign mif.mm_done   = mm_done_rsp | spur_done;
  assign mif.mm_result = mm_res;

  int n_cmp = 0;
  int n_err = 0;
  int start_cnt = 0;
  int lat = 3;

  typedef struct {
    logic [DW-1:0] res;
    int            starts;
  } exp_t;
  exp_t sb[$];

  mont_exp_ctrl #(.E_WIDTH(EW), .ELEN_W(LW)) dut (
    .clk     (clk),
    .resetn  (resetn),
    .start   (start),
    .in_x    (in_x),
    .in_e    (in_e),
    .in_elen (in_elen),
    .in_m    (in_m),
    .in_r    (in_r),
    .in_r2   (in_r2),
    .mm      (mif),
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [OPW-1:0] obs, input logic [OPW-1:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // a*b*2^-512 mod m, bit-serial
  function automatic logic [DW-1:0] mont_ref(input logic [OPW-1:0] a, input logic [OPW-1:0] b,
                                            input logic [OPW-1:0] m);
    logic [OPW+1:0] t;
    t = '0;
    for (int i = 0; i < DW; i++) begin
      if (a[i]) t = t + {2'b00, b};
      if (t[0]) t = t + {2'b00, m};
      t = t >> 1;
    end
    if (t >= {2'b00, m}) t = t - {2'b00, m};
    return t[DW-1:0];
  endfunction

  function automatic longint pow2mod(input int n, input longint m);
    longint r;
    r = 1 % m;
    for (int i = 0; i < n; i++) r = (r * 2) % m;
    return r;
  endfunction

  function automatic int clamp_elen(input int elen);
    return (elen > EW) ? EW : elen;
  endfunction

  function automatic longint modpow(input longint x, input logic [EW-1:0] e, input int elen,
                                    input longint m);
    longint acc;
    acc = 1 % m;
    for (int i = clamp_elen(elen) - 1; i >= 0; i--) begin
      acc = (acc * acc) % m;
      if (e[i]) acc = (acc * x) % m;
    end
    return acc;
  endfunction

  function automatic int op_count(input logic [EW-1:0] e, input int elen);
    int c;
    c = 2 + clamp_elen(elen);
    for (int i = 0; i < clamp_elen(elen); i++) if (e[i]) c++;
    return c;
  endfunction

  // Behavioural multiplier: fixed latency, aborts on reset, checks operand stability.
  initial begin
    logic [OPW-1:0] ca, cb, cm;
    logic [DW-1:0]  res;
    bit             stable, aborted;
    forever begin
      @(negedge clk);
      mm_done_rsp = 1'b0;
      if (resetn && mif.mm_start) begin
        start_cnt++;
        ca = mif.mm_a;
        cb = mif.mm_b;
        cm = mif.mm_m;
        res = mont_ref(ca, cb, cm);
        stable = 1'b1;
        aborted = 1'b0;
        for (int k = 0; k < lat && !aborted; k++) begin
          @(negedge clk);
          if (!resetn) aborted = 1'b1;
          else if (mif.mm_a !== ca || mif.mm_b !== cb || mif.mm_m !== cm) stable = 1'b0;
        end
        if (!aborted) begin
          check("operands_stable", {{(OPW-1){1'b0}}, stable}, OPW'(1));
          mm_res = res;
          mm_done_rsp = 1'b1;
        end
      end
    end
  end

  task automatic drive_ops(input longint x, input logic [EW-1:0] e, input int elen, input longint m);
    in_x    = DW'(x);
    in_e    = e;
    in_elen = LW'(elen);
    in_m    = DW'(m);
    in_r    = DW'(pow2mod(512, m));
    in_r2   = DW'(pow2mod(1024, m));
  endtask

  task automatic pulse_start(input longint x, input logic [EW-1:0] e, input int elen,
                             input longint m);
    @(negedge clk);
    drive_ops(x, e, elen, m);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", OPW'(busy), OPW'(1));
  endtask

  task automatic push_exp(input longint x, input logic [EW-1:0] e, input int elen,
                          input longint m);
    exp_t ex;
    ex.res    = DW'(modpow(x, e, elen, m));
    ex.starts = op_count(e, elen);
    sb.push_back(ex);
  endtask

  task automatic wait_done(input string tag);
    bit   got;
    exp_t ex;
    got = 1'b0;
    for (int k = 0; k < 20000; k++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    if (!got || sb.size() == 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL %s_done: observed no completion expected done with queued result", tag);
      if (sb.size() != 0) void'(sb.pop_front());
    end else begin
      ex = sb.pop_front();
      $display("%s: result=%0h mm_starts=%0d", tag, result, start_cnt);
      check({tag, "_result"}, OPW'(result), OPW'(ex.res));
      check({tag, "_mm_starts"}, OPW'(start_cnt), OPW'(ex.starts));
      check({tag, "_busy_on_done"}, OPW'(busy), OPW'(0));
      @(negedge clk);
      check({tag, "_done_width"}, OPW'(done), OPW'(0));
    end
  endtask

  task automatic run_op(input string tag, input longint x, input logic [EW-1:0] e,
                        input int elen, input longint m);
    start_cnt = 0;
    push_exp(x, e, elen, m);
    pulse_start(x, e, elen, m);
    wait_done(tag);
  endtask

  initial begin
    bit got;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", OPW'(busy), OPW'(0));
    check("rst_done", OPW'(done), OPW'(0));
    check("rst_result", OPW'(result), OPW'(0));
    check("rst_mm_start", OPW'(mif.mm_start), OPW'(0));
    check("rst_mm_a", mif.mm_a, OPW'(0));
    check("rst_mm_b", mif.mm_b, OPW'(0));
    check("rst_mm_m", mif.mm_m, OPW'(0));
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_busy", OPW'(busy), OPW'(0));

    lat = 3;
    run_op("pow_2_10", 2, EW'(10), 4, 1000003);
    run_op("x5_e1", 5, EW'(1), 1, 13);
    run_op("e0_elen4", 3, EW'(0), 4, 13);
    run_op("elen0", 3, EW'(5), 0, 13);
    run_op("m1", 0, EW'(5), 3, 1);

    lat = 20;
    run_op("stub_e1011", 7, EW'(11), 4, 1000003);

    // Second start while busy must be ignored
    start_cnt = 0;
    push_exp(6, EW'(13), 4, 1000003);
    pulse_start(6, EW'(13), 4, 1000003);
    repeat (3) @(negedge clk);
    pulse_start(9, EW'(200), 8, 97);
    wait_done("busy_restart");

    // Reset during the third multiplier operation
    start_cnt = 0;
    pulse_start(4, EW'(13), 4, 1000003);
    got = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      if (start_cnt >= 3) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!got) begin
      n_cmp++;
      n_err++;
      $error("FAIL third_op_reached: observed %0d launches expected 3", start_cnt);
    end
    repeat (2) @(negedge clk);
    resetn = 1'b0;
    #1;
    check("midrst_busy", OPW'(busy), OPW'(0));
    check("midrst_done", OPW'(done), OPW'(0));
    check("midrst_result", OPW'(result), OPW'(0));
    check("midrst_mm_start", OPW'(mif.mm_start), OPW'(0));
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    run_op("after_reset", 7, EW'(3), 2, 11);

    // Spurious mm_done in IDLE and during LAUNCH
    lat = 4;
    @(negedge clk);
    spur_done = 1'b1;
    @(negedge clk);
    spur_done = 1'b0;
    @(negedge clk);
    check("spur_idle_busy", OPW'(busy), OPW'(0));
    check("spur_idle_result", OPW'(result), OPW'(2));
    start_cnt = 0;
    push_exp(3, EW'(6), 3, 1000003);
    pulse_start(3, EW'(6), 3, 1000003);
    spur_done = 1'b1;
    @(negedge clk);
    spur_done = 1'b0;
    wait_done("spur_launch");

    // Exponent length beyond E_WIDTH is clamped
    lat = 1;
    run_op("elen_clamp", 5, EW'(5), 1000, 1000003);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
